// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg: HTRANS codes, data-phase owner encoding and holding-register record
package ahb_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_e;

    // control half of a captured address phase; the address is kept beside it at AW bits
    typedef struct packed {
        logic       hwrite;
        logic [2:0] hsize;
    } hold_ctl_t;

endpackage

// File: rtl/ahb_arb_req_buf.sv
// ahb_arb_req_buf: one port's losing address-phase capture register and HREADYOUT
module ahb_arb_req_buf
    import ahb_arb_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          capture,
    input  logic          issue,
    input  logic [AW-1:0] haddr,
    input  logic          hwrite,
    input  logic [2:0]    hsize,
    input  logic          is_owner,
    input  logic          m_hreadyout,
    output logic          buf_valid,
    output logic [AW-1:0] buf_haddr,
    output hold_ctl_t     buf_ctl,
    output logic          hreadyout
);

    // valid flag: set when this port loses, cleared on the edge it is issued
    always_ff @(posedge HCLK) begin
        if (HRESET) buf_valid <= 1'b0;
        else if (capture) buf_valid <= 1'b1;
        else if (issue) buf_valid <= 1'b0;
    end

    // captured address phase; only observed while buf_valid is set, so no reset needed
    always_ff @(posedge HCLK) begin
        if (capture) begin
            buf_haddr <= haddr;
            buf_ctl   <= '{hwrite: hwrite, hsize: hsize};
        end
    end

    assign hreadyout = buf_valid ? 1'b0 : is_owner ? m_hreadyout : 1'b1;

endmodule

// File: rtl/ahb_ram_arbiter.sv
// ahb_ram_arbiter: two AHB-Lite masters sharing one single-port RAM slave.
// Optional AHB_ARB_ROUND_ROBIN_EN: ties go to the port not granted last; otherwise P0 wins ties.
module ahb_ram_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          P0_HSEL,
    input  logic [AW-1:0] P0_HADDR,
    input  logic [1:0]    P0_HTRANS,
    input  logic          P0_HWRITE,
    input  logic [2:0]    P0_HSIZE,
    input  logic [DW-1:0] P0_HWDATA,
    input  logic          P0_HREADY,
    output logic          P0_HREADYOUT,
    output logic [DW-1:0] P0_HRDATA,
    input  logic          P1_HSEL,
    input  logic [AW-1:0] P1_HADDR,
    input  logic [1:0]    P1_HTRANS,
    input  logic          P1_HWRITE,
    input  logic [2:0]    P1_HSIZE,
    input  logic [DW-1:0] P1_HWDATA,
    input  logic          P1_HREADY,
    output logic          P1_HREADYOUT,
    output logic [DW-1:0] P1_HRDATA,
    output logic          M_HSEL,
    output logic [AW-1:0] M_HADDR,
    output logic [1:0]    M_HTRANS,
    output logic          M_HWRITE,
    output logic [2:0]    M_HSIZE,
    output logic [DW-1:0] M_HWDATA,
    output logic          M_HREADY,
    input  logic          M_HREADYOUT,
    input  logic [DW-1:0] M_HRDATA
);

    logic          arb, live0, live1, buf0, buf1, req0, req1, prio0, gnt0, gnt1;
    logic [AW-1:0] baddr0, baddr1, haddr_q;
    hold_ctl_t     bctl0, bctl1;
    owner_e        owner_q, owner_d;

    assign arb   = M_HREADYOUT & ~HRESET;
    assign live0 = P0_HSEL & P0_HTRANS[1] & P0_HREADY;
    assign live1 = P1_HSEL & P1_HTRANS[1] & P1_HREADY;
    // a buffered request shuts out any live request from the other port
    assign req0  = buf0 | (live0 & ~buf1);
    assign req1  = buf1 | (live1 & ~buf0);
    assign gnt0  = arb & req0 & (~req1 | prio0);
    assign gnt1  = arb & req1 & ~gnt0;
    assign owner_d = gnt0 ? OWN_P0 : gnt1 ? OWN_P1 : OWN_NONE;

`ifdef AHB_ARB_ROUND_ROBIN_EN
    logic rr_q;
    // rr_q=1 means P1 was granted last, so P0 takes the next tie
    always_ff @(posedge HCLK) begin
        if (HRESET) rr_q <= 1'b1;
        else if (gnt0 | gnt1) rr_q <= gnt1;
    end
    assign prio0 = rr_q;
`else
    assign prio0 = 1'b1;
`endif

    // data-phase owner only advances when the slave completes the current data phase
    always_ff @(posedge HCLK) begin
        if (HRESET) owner_q <= OWN_NONE;
        else if (arb) owner_q <= owner_d;
    end

    // remember the last issued address so M_HADDR is stable while idle
    always_ff @(posedge HCLK) begin
        if (HRESET) haddr_q <= '0;
        else if (gnt0 | gnt1) haddr_q <= M_HADDR;
    end

    // winner drives the slave address phase; buffered transfers restart as NONSEQ
    always_comb begin
        M_HSEL   = gnt0 | gnt1;
        M_HADDR  = gnt0 ? (buf0 ? baddr0 : P0_HADDR) : gnt1 ? (buf1 ? baddr1 : P1_HADDR) : haddr_q;
        M_HTRANS = gnt0 ? (buf0 ? HTRANS_NONSEQ : P0_HTRANS) : gnt1 ? (buf1 ? HTRANS_NONSEQ : P1_HTRANS) : HTRANS_IDLE;
        M_HWRITE = gnt0 ? (buf0 ? bctl0.hwrite : P0_HWRITE) : gnt1 ? (buf1 ? bctl1.hwrite : P1_HWRITE) : 1'b0;
        M_HSIZE  = gnt0 ? (buf0 ? bctl0.hsize : P0_HSIZE) : gnt1 ? (buf1 ? bctl1.hsize : P1_HSIZE) : 3'b000;
    end

    assign M_HWDATA  = owner_q == OWN_P0 ? P0_HWDATA : owner_q == OWN_P1 ? P1_HWDATA : '0;
    assign M_HREADY  = M_HREADYOUT;
    assign P0_HRDATA = M_HRDATA;
    assign P1_HRDATA = M_HRDATA;

    ahb_arb_req_buf #(.AW(AW)) u_buf0 (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .capture     (arb & live0 & ~gnt0 & ~buf0),
        .issue       (gnt0 & buf0),
        .haddr       (P0_HADDR),
        .hwrite      (P0_HWRITE),
        .hsize       (P0_HSIZE),
        .is_owner    (owner_q == OWN_P0),
        .m_hreadyout (M_HREADYOUT),
        .buf_valid   (buf0),
        .buf_haddr   (baddr0),
        .buf_ctl     (bctl0),
        .hreadyout   (P0_HREADYOUT)
    );

    ahb_arb_req_buf #(.AW(AW)) u_buf1 (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .capture     (arb & live1 & ~gnt1 & ~buf1),
        .issue       (gnt1 & buf1),
        .haddr       (P1_HADDR),
        .hwrite      (P1_HWRITE),
        .hsize       (P1_HSIZE),
        .is_owner    (owner_q == OWN_P1),
        .m_hreadyout (M_HREADYOUT),
        .buf_valid   (buf1),
        .buf_haddr   (baddr1),
        .buf_ctl     (bctl1),
        .hreadyout   (P1_HREADYOUT)
    );

endmodule

// File: tb/tb_ahb_ram_arbiter.sv
// tb_ahb_ram_arbiter: directed cycle vectors against a small RAM slave model
module tb_ahb_ram_arbiter;

`ifdef AHB_ARB_ROUND_ROBIN_EN
    localparam logic RR = 1'b1;
`else
    localparam logic RR = 1'b0;
`endif
    localparam logic       H  = 1'b1;
    localparam logic       L  = 1'b0;
    localparam logic [1:0] I  = 2'b00;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;
    localparam logic [31:0] Z = 32'h0;

    logic        HCLK, HRESET;
    logic        P0_HSEL, P0_HWRITE, P0_HREADYOUT, P1_HSEL, P1_HWRITE, P1_HREADYOUT;
    logic [1:0]  P0_HTRANS, P1_HTRANS, M_HTRANS;
    logic [2:0]  P0_HSIZE, P1_HSIZE, M_HSIZE;
    logic [31:0] P0_HADDR, P0_HWDATA, P0_HRDATA, P1_HADDR, P1_HWDATA, P1_HRDATA;
    logic        M_HSEL, M_HWRITE, M_HREADY, M_HREADYOUT;
    logic [31:0] M_HADDR, M_HWDATA, M_HRDATA;

    int n_chk = 0;
    int n_fail = 0;

    ahb_ram_arbiter #(.AW(32), .DW(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .P0_HSEL(P0_HSEL), .P0_HADDR(P0_HADDR), .P0_HTRANS(P0_HTRANS), .P0_HWRITE(P0_HWRITE),
        .P0_HSIZE(P0_HSIZE), .P0_HWDATA(P0_HWDATA), .P0_HREADY(P0_HREADYOUT),
        .P0_HREADYOUT(P0_HREADYOUT), .P0_HRDATA(P0_HRDATA),
        .P1_HSEL(P1_HSEL), .P1_HADDR(P1_HADDR), .P1_HTRANS(P1_HTRANS), .P1_HWRITE(P1_HWRITE),
        .P1_HSIZE(P1_HSIZE), .P1_HWDATA(P1_HWDATA), .P1_HREADY(P1_HREADYOUT),
        .P1_HREADYOUT(P1_HREADYOUT), .P1_HRDATA(P1_HRDATA),
        .M_HSEL(M_HSEL), .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE),
        .M_HSIZE(M_HSIZE), .M_HWDATA(M_HWDATA), .M_HREADY(M_HREADY),
        .M_HREADYOUT(M_HREADYOUT), .M_HRDATA(M_HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // RAM slave: 16 words, word index = HADDR[5:2], preset to C0DE_00xx on reset
    logic [31:0] mem [16];
    logic        dp_v, dp_w;
    logic [3:0]  dp_i;
    always @(posedge HCLK) begin
        if (HRESET) begin
            for (int k = 0; k < 16; k++) mem[k] <= 32'hC0DE_0000 + 32'(k);
            dp_v <= 1'b0;
            dp_w <= 1'b0;
            dp_i <= 4'd0;
        end else if (M_HREADY) begin
            if (dp_v && dp_w) mem[dp_i] <= M_HWDATA;
            dp_v <= M_HSEL & M_HTRANS[1];
            dp_w <= M_HWRITE;
            dp_i <= M_HADDR[5:2];
        end
    end
    assign M_HRDATA = mem[dp_i];

    typedef struct {
        logic [1:0]  t0; logic w0; logic [31:0] a0; logic [31:0] d0;
        logic [1:0]  t1; logic w1; logic [31:0] a1; logic [31:0] d1;
        logic        rdy;
        logic [1:0]  e_tr; logic [31:0] e_ad; logic e_wr; logic [31:0] e_wd;
        logic        e_r0; logic e_r1; logic rchk; logic [31:0] e_rd;
    } vec_t;
    vec_t v [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] t0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic [1:0] t1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                         input logic rdy);
        P0_HSEL = |t0; P0_HTRANS = t0; P0_HWRITE = w0; P0_HADDR = a0; P0_HWDATA = d0;
        P1_HSEL = |t1; P1_HTRANS = t1; P1_HWRITE = w1; P1_HADDR = a1; P1_HWDATA = d1;
        M_HREADYOUT = rdy;
    endtask

    initial begin
        // t0 w0 a0 d0 | t1 w1 a1 d1 | rdy || e_tr e_ad e_wr e_wd | e_r0 e_r1 rchk e_rd
        // single P0 write then readback
        v.push_back('{NS, H, 32'h10, Z, I, L, Z, Z, H, NS, 32'h10, H, Z, H, H, L, Z});
        v.push_back('{I, L, Z, 32'hA5A5A5A5, I, L, Z, Z, H, I, 32'h10, L, 32'hA5A5A5A5, H, H, L, Z});
        v.push_back('{NS, L, 32'h10, Z, I, L, Z, Z, H, NS, 32'h10, L, Z, H, H, L, Z});
        v.push_back('{I, L, Z, Z, I, L, Z, Z, H, I, 32'h10, L, Z, H, H, H, 32'hA5A5A5A5});
        // simultaneous reads: P0 first, P1 from its buffer next cycle
        v.push_back('{NS, L, 32'h10, Z, NS, L, 32'h20, Z, H, NS, 32'h10, L, Z, H, H, L, Z});
        v.push_back('{I, L, Z, Z, I, L, Z, Z, H, NS, 32'h20, L, Z, H, L, H, 32'hA5A5A5A5});
        v.push_back('{I, L, Z, Z, I, L, Z, Z, H, I, 32'h20, L, Z, H, H, H, 32'hC0DE0008});
        // buffered P1 beats P0's live SEQ; P0 then restarts as NONSEQ
        v.push_back('{NS, L, 32'h00, Z, NS, L, 32'h24, Z, H, NS, 32'h00, L, Z, H, H, L, Z});
        v.push_back('{SQ, L, 32'h04, Z, I, L, Z, Z, H, NS, 32'h24, L, Z, H, L, H, 32'hC0DE0000});
        v.push_back('{SQ, L, 32'h08, Z, I, L, Z, Z, H, NS, 32'h04, L, Z, L, H, H, 32'hC0DE0009});
        v.push_back('{SQ, L, 32'h08, Z, I, L, Z, Z, H, SQ, 32'h08, L, Z, H, H, H, 32'hC0DE0001});
        v.push_back('{I, L, Z, Z, I, L, Z, Z, H, I, 32'h08, L, Z, H, H, H, 32'hC0DE0002});
        // two slave wait states: no arbitration, buffer held
        v.push_back('{NS, L, 32'h0C, Z, NS, L, 32'h28, Z, H, NS, 32'h0C, L, Z, H, H, L, Z});
        v.push_back('{I, L, Z, Z, I, L, Z, Z, L, I, 32'h0C, L, Z, L, L, L, Z});
        v.push_back('{I, L, Z, Z, I, L, Z, Z, L, I, 32'h0C, L, Z, L, L, L, Z});
        v.push_back('{I, L, Z, Z, I, L, Z, Z, H, NS, 32'h28, L, Z, H, L, H, 32'hC0DE0003});
        v.push_back('{I, L, Z, Z, I, L, Z, Z, H, I, 32'h28, L, Z, H, H, H, 32'hC0DE000A});
        // colliding writes: write data follows the data-phase owner
        v.push_back('{NS, H, 32'h30, Z, NS, H, 32'h34, Z, H, NS, 32'h30, H, Z, H, H, L, Z});
        v.push_back('{I, L, Z, 32'h11111111, I, L, Z, 32'h22222222, H, NS, 32'h34, H, 32'h11111111, H, L, L, Z});
        v.push_back('{I, L, Z, Z, I, L, Z, 32'h22222222, H, I, 32'h34, L, 32'h22222222, H, H, L, Z});
        v.push_back('{NS, L, 32'h34, Z, I, L, Z, Z, H, NS, 32'h34, L, Z, H, H, L, Z});
        v.push_back('{I, L, Z, Z, I, L, Z, Z, H, I, 32'h34, L, Z, H, H, H, 32'h22222222});
        // tie right after a P0 grant: round robin picks P1, fixed priority picks P0
        v.push_back('{NS, L, 32'h00, Z, I, L, Z, Z, H, NS, 32'h00, L, Z, H, H, L, Z});
        v.push_back('{NS, L, 32'h04, Z, NS, L, 32'h08, Z, H, NS, RR ? 32'h08 : 32'h04, L, Z, H, H, H, 32'hC0DE0000});
        v.push_back('{I, L, Z, Z, I, L, Z, Z, H, NS, RR ? 32'h04 : 32'h08, L, Z, RR ? L : H, RR ? H : L, L, Z});
        v.push_back('{I, L, Z, Z, I, L, Z, Z, H, I, RR ? 32'h04 : 32'h08, L, Z, H, H, H, RR ? 32'hC0DE0001 : 32'hC0DE0002});

        P0_HSIZE = 3'b010;
        P1_HSIZE = 3'b010;
        HRESET = 1'b1;
        drive(I, L, Z, 32'hDEADBEEF, I, L, Z, 32'hDEADBEEF, H);
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;
        #2;
        chk("reset hsel", 32'(M_HSEL), 32'(L));
        chk("reset htrans", 32'(M_HTRANS), 32'(I));
        chk("reset hwdata", M_HWDATA, Z);
        chk("reset rdy0", 32'(P0_HREADYOUT), 32'(H));
        chk("reset rdy1", 32'(P1_HREADYOUT), 32'(H));

        foreach (v[i]) begin
            @(negedge HCLK);
            drive(v[i].t0, v[i].w0, v[i].a0, v[i].d0, v[i].t1, v[i].w1, v[i].a1, v[i].d1, v[i].rdy);
            #2;
            chk($sformatf("v%0d hsel", i), 32'(M_HSEL), 32'(|v[i].e_tr));
            chk($sformatf("v%0d htrans", i), 32'(M_HTRANS), 32'(v[i].e_tr));
            chk($sformatf("v%0d haddr", i), M_HADDR, v[i].e_ad);
            chk($sformatf("v%0d hwrite", i), 32'(M_HWRITE), 32'(v[i].e_wr));
            chk($sformatf("v%0d hwdata", i), M_HWDATA, v[i].e_wd);
            chk($sformatf("v%0d rdy0", i), 32'(P0_HREADYOUT), 32'(v[i].e_r0));
            chk($sformatf("v%0d rdy1", i), 32'(P1_HREADYOUT), 32'(v[i].e_r1));
            if (v[i].rchk) begin
                chk($sformatf("v%0d rdata0", i), P0_HRDATA, v[i].e_rd);
                chk($sformatf("v%0d rdata1", i), P1_HRDATA, v[i].e_rd);
            end
        end

        // reset while P1 holds a buffered transfer
        @(negedge HCLK);
        drive(NS, L, 32'h00, Z, NS, L, 32'h04, Z, H);
        @(negedge HCLK);
        drive(I, L, Z, 32'hFFFFFFFF, I, L, Z, Z, H);
        #2;
        chk("rst buf1 stall", 32'(P1_HREADYOUT), 32'(L));
        HRESET = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0;
        drive(I, L, Z, 32'hFFFFFFFF, I, L, Z, 32'hFFFFFFFF, L);
        #2;
        chk("rst rdy1", 32'(P1_HREADYOUT), 32'(H));
        chk("rst rdy0 no owner", 32'(P0_HREADYOUT), 32'(H));
        chk("rst htrans", 32'(M_HTRANS), 32'(I));
        chk("rst hsel", 32'(M_HSEL), 32'(L));
        chk("rst hwdata", M_HWDATA, Z);
        @(negedge HCLK);
        M_HREADYOUT = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
